// File: rtl/sdram_wr_burst_packer.sv
// Packs async-FIFO words into BURST_LEN-beat SDRAM write bursts: fill, command, stream.
// Define SDRAM_PKR_FLUSH_EN to flush partial bursts after FLUSH_CYC idle cycles.
module sdram_wr_burst_packer #(
    parameter int WIDTH      = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_W      = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int FLUSH_CYC  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [WIDTH-1:0]      i_fifo_rd_data,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [CNT_W-1:0]      o_cmd_len,
    input  logic                  i_wdata_req,
    output logic [WIDTH-1:0]      o_wdata,
    output logic                  o_wdata_mask,
    output logic                  o_busy
);
    localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);
    localparam int IDX_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {FILL, REQ, SEND} state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CNT_W-1:0]        r_issued;
    logic [CNT_W-1:0]        r_rcvd;
    logic [CNT_W-1:0]        r_beat;
    logic [CNT_W-1:0]        r_cmdLen;
    logic                    r_rdPend;
    logic [ADDR_WIDTH-1:0]   r_addrPtr;
    logic [WIDTH-1:0]        r_buf [BURST_LEN];
    logic [WIDTH-1:0]        r_wdata;
    logic                    w_beatAccept;
    logic                    w_flush;

    if (2**CNT_W <= BURST_LEN || FLUSH_CYC < 1) begin : g_paramCheck
        $error("sdram_wr_burst_packer: CNT_W too narrow for BURST_LEN or FLUSH_CYC < 1");
    end

`ifdef SDRAM_PKR_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYC + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_wdataMask;
    logic              w_flushEligible;

    // Idle timer only runs while a partial burst sits fully received in the buffer.
    assign w_flushEligible = (r_state == FILL) && (r_rcvd != '0) && (r_rcvd < BL) && (r_issued == r_rcvd);
    assign w_flush         = w_flushEligible && (r_idle == IDLE_W'(FLUSH_CYC));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle <= '0;
        end else if (!w_flushEligible || o_fifo_rd_en) begin
            r_idle <= '0;
        end else if (i_fifo_empty && r_idle != IDLE_W'(FLUSH_CYC)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdataMask <= 1'b0;
        end else begin
            r_wdataMask <= w_beatAccept && (r_beat >= r_cmdLen);
        end
    end

    assign o_wdata_mask = r_wdataMask;
`else
    assign w_flush      = 1'b0;
    assign o_wdata_mask = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pops stop once a full burst is issued or a flush is firing, so no word is stranded in flight.
    always_comb begin
        w_nextState  = r_state;
        o_fifo_rd_en = 1'b0;
        o_cmd_valid  = 1'b0;
        w_beatAccept = 1'b0;
        case (r_state)
            FILL: begin
                o_fifo_rd_en = ~i_rst & ~i_fifo_empty & (r_issued < BL) & ~w_flush;
                if (r_rcvd == BL || w_flush) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                o_cmd_valid = 1'b1;
                if (i_cmd_ready) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (r_beat == BL) begin
                    w_nextState = FILL;
                end else begin
                    w_beatAccept = i_wdata_req;
                end
            end
            default: w_nextState = FILL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdPend  <= 1'b0;
            r_issued  <= '0;
            r_rcvd    <= '0;
            r_beat    <= '0;
            r_cmdLen  <= '0;
            r_addrPtr <= '0;
            r_wdata   <= '0;
        end else begin
            r_rdPend <= o_fifo_rd_en;
            if (o_fifo_rd_en) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            if (r_rdPend) begin
                r_rcvd <= r_rcvd + CNT_W'(1);
            end
            if (r_state == FILL && w_nextState == REQ) begin
                r_cmdLen <= w_flush ? r_rcvd : BL;
            end
            if (o_cmd_valid && i_cmd_ready) begin
                r_addrPtr <= r_addrPtr + ADDR_WIDTH'(BURST_LEN);
            end
            if (w_beatAccept) begin
                r_beat <= r_beat + CNT_W'(1);
            end
            // Last beat has been on the bus for a cycle: the buffer is free for the next burst.
            if (r_state == SEND && r_beat == BL) begin
                r_issued <= '0;
                r_rcvd   <= '0;
                r_beat   <= '0;
            end
            r_wdata <= (w_beatAccept && r_beat < r_cmdLen) ? r_buf[r_beat[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_rdPend) begin
            r_buf[r_rcvd[IDX_W-1:0]] <= i_fifo_rd_data;
        end
    end

    assign o_cmd_addr = r_addrPtr;
    assign o_cmd_len  = r_cmdLen;
    assign o_wdata    = r_wdata;
    assign o_busy     = (r_state != FILL) || (r_issued != '0);

endmodule

// File: tb/tb_sdram_wr_burst_packer.sv
// Directed bench for sdram_wr_burst_packer with a FIFO model and a burst-level scoreboard.
// Works with SDRAM_PKR_FLUSH_EN defined or undefined.
module tb_sdram_wr_burst_packer;
    localparam int BL = 4;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          fifoEmpty;
    logic          fifoRdEn;
    logic [7:0]    fifoRdData;
    logic          cmdValid;
    logic          cmdReady;
    logic [AW-1:0] cmdAddr;
    logic [2:0]    cmdLen;
    logic          wdataReq;
    logic [7:0]    wdata;
    logic          wdataMask;
    logic          busy;

    sdram_wr_burst_packer #(
        .WIDTH(8), .BURST_LEN(BL), .CNT_W(3), .ADDR_WIDTH(AW), .FLUSH_CYC(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifoEmpty), .o_fifo_rd_en(fifoRdEn),
        .i_fifo_rd_data(fifoRdData), .o_cmd_valid(cmdValid), .i_cmd_ready(cmdReady),
        .o_cmd_addr(cmdAddr), .o_cmd_len(cmdLen), .i_wdata_req(wdataReq),
        .o_wdata(wdata), .o_wdata_mask(wdataMask), .o_busy(busy)
    );

    int vectorCount = 0;
    int missCount   = 0;

    // FIFO model: pushes from the stimulus, pops when the DUT asks.
    logic [7:0] fifoMem [256];
    int         wp = 0;
    int         rp = 0;
    logic       forceEmpty = 1'b0;
    logic       toggleEmpty = 1'b0;
    assign fifoEmpty = forceEmpty || (wp == rp);

    // Burst-level model state.
    logic [7:0]    popQ [$];
    logic [7:0]    burstWords [BL];
    int            beatsLeft = 0;
    int            beatIdx = 0;
    int            curLen = 0;
    int            cmdCount = 0;
    int            cyc = 0;
    int            popTimes [$];
    logic [AW-1:0] addrModel = '0;
    logic [AW-1:0] lastCmdAddr = '0;
    logic [AW-1:0] addrLog [$];
    logic [2:0]    lastCmdLen = '0;
    logic          expValid = 1'b0;
    logic [7:0]    expData = '0;
    logic          expMask = 1'b0;
    logic [7:0]    capData [$];
    logic          capMask [$];
    logic          sawValid = 1'b0;
    int            reqMode = 2;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Burst length follows from how many words have been popped but not yet commanded.
    function automatic int modelLen();
`ifdef SDRAM_PKR_FLUSH_EN
        return (popQ.size() < BL) ? popQ.size() : BL;
`else
        return BL;
`endif
    endfunction

    task automatic applyStimulus(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifoMem[wp] = 8'(base + i);
            wp++;
        end
    endtask

    task automatic waitBursts(input int target, input int limit, input string name);
        int n = 0;
        while ((cmdCount < target || beatsLeft > 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done_in_time"}, n < limit, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkBeats(input string name, input logic [7:0] base, input int n);
        checkOutput({name, "_beat_count"}, capData.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < capData.size()) begin
                checkOutput({name, "_beat"}, capData[i], 8'(base + i));
                checkOutput({name, "_mask"}, capMask[i], 0);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        case (reqMode)
            0: wdataReq = 1'b1;
            1: wdataReq = ~wdataReq;
            2: wdataReq = 1'b0;
            default: ;
        endcase
        if (toggleEmpty) forceEmpty = ~forceEmpty;
    end

    // Model update on each rising edge from pre-edge handshakes.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            popQ.delete();
            beatsLeft = 0;
            expValid  = 1'b0;
            addrModel = '0;
        end else begin
            if (wdataReq && beatsLeft > 0) begin
                expValid = 1'b1;
                expMask  = (beatIdx >= curLen);
                expData  = expMask ? 8'h00 : burstWords[beatIdx];
                beatIdx++;
                beatsLeft--;
            end else begin
                expValid = 1'b0;
            end
            if (cmdValid && cmdReady) begin
                lastCmdAddr = cmdAddr;
                lastCmdLen  = cmdLen;
                addrLog.push_back(cmdAddr);
                curLen = modelLen();
                for (int i = 0; i < curLen; i++) burstWords[i] = popQ.pop_front();
                beatIdx   = 0;
                beatsLeft = BL;
                addrModel = addrModel + AW'(BL);
                cmdCount++;
            end
            if (fifoRdEn) begin
                checkOutput("pop_when_empty", fifoEmpty, 0);
                checkOutput("pop_outside_fill", (beatsLeft > 0) || cmdValid, 0);
                checkOutput("pop_over_burst", popQ.size() >= BL, 0);
                if (!fifoEmpty) begin
                    popQ.push_back(fifoMem[rp]);
                    popTimes.push_back(cyc);
                    fifoRdData <= fifoMem[rp];
                    rp <= rp + 1;
                end
            end
        end
    end

    // Output compare, mid-cycle.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            checkOutput("reset_outputs", {fifoRdEn, cmdValid, cmdAddr, cmdLen, wdata, wdataMask, busy}, 0);
        end else begin
            if (cmdValid) begin
                sawValid = 1'b1;
                checkOutput("cmd_addr", cmdAddr, addrModel);
                checkOutput("cmd_len", cmdLen, modelLen());
                checkOutput("rd_en_in_req", fifoRdEn, 0);
            end
            if (expValid) begin
                capData.push_back(wdata);
                capMask.push_back(wdataMask);
            end
            checkOutput("wdata", wdata, expValid ? expData : 8'h00);
            checkOutput("wdata_mask", wdataMask, expValid ? expMask : 1'b0);
            if (popQ.size() > 0 || beatsLeft > 0) checkOutput("busy", busy, 1);
        end
    end

    initial begin
        int n;
        int done;
        rst      = 1'b1;
        cmdReady = 1'b0;
        wdataReq = 1'b0;
        repeat (3) @(negedge clk);
        #3 checkOutput("reset_state", {fifoRdEn, cmdValid, cmdAddr, cmdLen, wdata, wdataMask, busy}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single full burst, back-to-back beat requests.
        cmdReady = 1'b1;
        reqMode  = 0;
        popTimes.delete();
        applyStimulus(8'hA0, 4);
        waitBursts(1, 100, "t1");
        checkOutput("t1_addr", lastCmdAddr, 0);
        checkOutput("t1_len", lastCmdLen, 4);
        checkOutput("t1_pop_count", popTimes.size(), 4);
        if (popTimes.size() >= 4) checkOutput("t1_pops_consecutive", popTimes[3] - popTimes[0], 3);
        checkBeats("t1", 8'hA0, 4);

        // Command held off for 10 cycles with more data waiting.
        cmdReady = 1'b0;
        capData.delete(); capMask.delete();
        applyStimulus(8'hB0, 8);
        n = 0;
        while (!cmdValid && n < 50) begin @(negedge clk); n++; end
        checkOutput("t2_valid_in_time", n < 50, 1);
        repeat (10) begin
            @(negedge clk);
            #3;
            checkOutput("t2_hold_valid", cmdValid, 1);
            checkOutput("t2_hold_addr", cmdAddr, 4);
            checkOutput("t2_hold_len", cmdLen, 4);
            checkOutput("t2_hold_no_pop", fifoRdEn, 0);
        end
        @(negedge clk);
        cmdReady = 1'b1;
        waitBursts(3, 200, "t2");
        checkBeats("t2", 8'hB0, 8);

        // Address wrap: 9th burst lands back at 0.
        reqMode = 1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'(8'h40 + 4 * k), 4);
            waitBursts(4 + k, 200, "t3");
        end
        checkOutput("t3_addr_log_size", addrLog.size(), 9);
        if (addrLog.size() >= 9) checkOutput("t3_addr_before_wrap", addrLog[7], 28);
        checkOutput("t3_wrap_addr", lastCmdAddr, 0);

        // Reset after two of four beats.
        reqMode  = 3;
        wdataReq = 1'b0;
        capData.delete(); capMask.delete();
        applyStimulus(8'hC0, 4);
        applyStimulus(8'hD0, 4);
        n = 0;
        while (cmdCount < 10 && n < 100) begin @(negedge clk); n++; end
        checkOutput("t4_cmd_in_time", n < 100, 1);
        wdataReq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wdataReq = 1'b0;
        @(negedge clk);
        #3;
        checkBeats("t4_partial", 8'hC0, 2);
        checkOutput("t4_busy_before_reset", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("t4_reset_outputs", {fifoRdEn, cmdValid, cmdAddr, cmdLen, wdata, wdataMask, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        reqMode = 0;
        capData.delete(); capMask.delete();
        waitBursts(11, 200, "t4");
        checkOutput("t4_addr_after_reset", lastCmdAddr, 0);
        checkBeats("t4", 8'hD0, 4);

        // Partial burst: flushed when enabled, otherwise it waits.
        capData.delete(); capMask.delete();
        sawValid = 1'b0;
        applyStimulus(8'hE0, 3);
`ifdef SDRAM_PKR_FLUSH_EN
        waitBursts(12, 100, "t5_flush");
        checkOutput("t5_flush_len", lastCmdLen, 3);
        checkOutput("t5_beat_count", capData.size(), 4);
        if (capData.size() >= 4) begin
            checkOutput("t5_beat0", capData[0], 8'hE0);
            checkOutput("t5_beat2", capData[2], 8'hE2);
            checkOutput("t5_pad_data", capData[3], 8'h00);
            checkOutput("t5_mask2", capMask[2], 0);
            checkOutput("t5_pad_mask", capMask[3], 1);
        end
        applyStimulus(8'hE3, 1);
        waitBursts(13, 100, "t5_single");
        done = 13;
`else
        repeat (100) @(negedge clk);
        #3;
        checkOutput("t5_no_flush_valid", sawValid, 0);
        checkOutput("t5_partial_busy", busy, 1);
        applyStimulus(8'hE3, 1);
        waitBursts(12, 100, "t5");
        checkBeats("t5", 8'hE0, 4);
        done = 12;
`endif

        // FIFO empty flag toggling every cycle.
        capData.delete(); capMask.delete();
        toggleEmpty = 1'b1;
        applyStimulus(8'hF0, 8);
        waitBursts(done + 2, 300, "t6");
        toggleEmpty = 1'b0;
        forceEmpty  = 1'b0;
        checkBeats("t6", 8'hF0, 8);

        repeat (5) @(negedge clk);
        #3;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", cmdValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
